// File: rtl/bram_reader_pkg.sv
// Shared types and read-latency configuration for bram_stream_reader.
// Define BRAM_STREAM_READER_OUTREG_EN when the RAM carries an output register (RdLat=2).
package bram_reader_pkg;

`ifdef BRAM_STREAM_READER_OUTREG_EN
  localparam int RdLat = 2;
`else
  localparam int RdLat = 1;
`endif

  // One slot per read that can be in the RAM pipeline, plus the one being presented.
  localparam int FifoDepth    = RdLat + 1;
  localparam int DefDataWidth = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  typedef struct packed {
    logic [DefDataWidth-1:0] data;
    logic                    last;
  } Beat_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// Small synchronous FIFO whose head entry is a flop, so the output side is fully registered.
// Entries shift toward slot 0 on pop; a push while full is legal only together with a pop.
module stream_skid_fifo
  import bram_reader_pkg::*;
#(
  parameter int  Depth = FifoDepth,
  parameter type T     = Beat_t,
  localparam int CW    = $clog2(Depth + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  T              in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output T              out_data_o,
  output logic [CW-1:0] count_o
);

  T              mem_q [Depth];
  T              mem_d [Depth];
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign out_valid_o = (count_q != '0);
  assign pop         = out_valid_o && out_ready_i;
  assign in_ready_o  = (count_q < CW'(Depth)) || pop;
  assign push        = in_valid_i && in_ready_o;
  assign out_data_o  = mem_q[0];
  assign count_o     = count_q;

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (pop) begin
      for (int i = 0; i < Depth - 1; i++) mem_d[i] = mem_q[i+1];
      count_d = count_d - CW'(1);
    end
    if (push) begin
      for (int i = 0; i < Depth; i++)
        if (count_d == CW'(i)) mem_d[i] = in_data_i;
      count_d = count_d + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Burst reader: issues strided RAM reads under a credit limit and streams the words out.
// BRAM_STREAM_READER_OUTREG_EN (see bram_reader_pkg) selects RdLat=2 for output-registered RAMs.
module bram_stream_reader
  import bram_reader_pkg::*;
#(
  parameter int  DataWidth = 16,
  parameter int  Size      = 512,
  parameter int  MaxLen    = 512,
  localparam int AW        = $clog2(Size),
  localparam int LW        = $clog2(MaxLen + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [AW-1:0]        cmd_addr,
  input  logic [LW-1:0]        cmd_len,
  input  logic [AW-1:0]        cmd_stride,
  output logic                 bram_en,
  output logic [AW-1:0]        bram_addr,
  input  logic [DataWidth-1:0] bram_dout,
  output logic [DataWidth-1:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic                 busy
);

  localparam int CW = $clog2(FifoDepth + 1);

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic                 last;
  } beat_t;

  state_e           state_q, state_d;
  logic [AW-1:0]    cur_q, cur_d, stride_q, stride_d, cur_wrap;
  logic [LW-1:0]    rem_q, rem_d;
  logic [RdLat-1:0] vld_pipe_q, last_pipe_q;
  logic [AW:0]      addr_sum;
  logic [CW-1:0]    in_flight, fifo_count;
  logic [CW:0]      occupancy;
  logic             issue, pop, fifo_valid;
  logic             unused_fifo_in_ready;
  beat_t            fifo_in, fifo_out;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RdLat; i++) in_flight = in_flight + CW'(vld_pipe_q[i]);
  end

  // Counting this cycle's pop as freed space is what allows one issue per cycle at full rate.
  assign pop       = fifo_valid && m_tready;
  assign occupancy = {1'b0, in_flight} + {1'b0, fifo_count} - (CW+1)'(pop);
  assign issue     = (state_q == ISSUE) && (occupancy < (CW+1)'(FifoDepth)) && !rst;

  assign addr_sum = {1'b0, cur_q} + {1'b0, stride_q};
  assign cur_wrap = (addr_sum >= (AW+1)'(Size)) ? AW'(addr_sum - (AW+1)'(Size))
                                                : addr_sum[AW-1:0];

  assign cmd_ready = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE) && !rst;
  assign bram_en   = issue;
  assign bram_addr = cur_q;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    stride_d = stride_q;
    rem_d    = rem_q;
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        cur_d    = cmd_addr;
        stride_d = cmd_stride;
        rem_d    = cmd_len;
        if (cmd_len != '0) state_d = ISSUE;
      end
      ISSUE: if (issue) begin
        cur_d = cur_wrap;
        rem_d = rem_q - LW'(1);
        if (rem_q == LW'(1)) state_d = DRAIN;
      end
      DRAIN: if (pop && fifo_out.last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      stride_q    <= '0;
      rem_q       <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else begin
      state_q        <= state_d;
      cur_q          <= cur_d;
      stride_q       <= stride_d;
      rem_q          <= rem_d;
      vld_pipe_q[0]  <= issue;
      last_pipe_q[0] <= (rem_q == LW'(1));
      for (int i = 1; i < RdLat; i++) begin
        vld_pipe_q[i]  <= vld_pipe_q[i-1];
        last_pipe_q[i] <= last_pipe_q[i-1];
      end
    end
  end

  assign fifo_in.data = bram_dout;
  assign fifo_in.last = last_pipe_q[RdLat-1];

  stream_skid_fifo #(
    .Depth (FifoDepth),
    .T     (beat_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (vld_pipe_q[RdLat-1]),
    .in_ready_o  (unused_fifo_in_ready),
    .in_data_i   (fifo_in),
    .out_valid_o (fifo_valid),
    .out_ready_i (m_tready),
    .out_data_o  (fifo_out),
    .count_o     (fifo_count)
  );

  assign m_tdata  = fifo_out.data;
  assign m_tvalid = fifo_valid;
  assign m_tlast  = fifo_valid && fifo_out.last;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: behavioural RAM plus a queue model of each burst's expected
// addresses and beats, with directed and randomized bursts, backpressure and reset.
`timescale 1ns/1ps
module tb_bram_stream_reader;

  localparam int DW = 16, Size = 512, MaxLen = 512, AW = 9, LW = 10;
`ifdef BRAM_STREAM_READER_OUTREG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif
  localparam int Depth = Lat + 1, FirstLat = Lat + 2;

  logic          clk = 1'b0, rst = 1'b1;
  logic          cmd_valid, cmd_ready, bram_en, m_tvalid, m_tready, m_tlast, busy;
  logic [AW-1:0] cmd_addr, cmd_stride, bram_addr;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] bram_dout, m_tdata, rd1, rd2;
  logic [DW-1:0] mem [Size];
  int            tests = 0, fails = 0;

  bram_stream_reader #(.DataWidth(DW), .Size(Size), .MaxLen(MaxLen)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_stride(cmd_stride),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_en) rd1 <= mem[bram_addr];
    rd2 <= rd1;
  end
`ifdef BRAM_STREAM_READER_OUTREG_EN
  assign bram_dout = rd2;
`else
  assign bram_dout = rd1;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Offers a command (expected to be taken on the first cycle), then tracks the burst until
  // its last handshake, or until max_beats beats when aborting. With hold set, the next
  // command is kept on the command port for the whole burst.
  task automatic run_burst(input int a, input int n, input int s, input int pct,
                           input int max_beats, input bit hold,
                           input int na, input int nn, input int ns);
    logic [DW-1:0] exp_d[$];
    bit            exp_l[$];
    int            addr_q[$];
    int            acc = -1, got = 0, issued = 0, first = -1, first_hs = -1, last_hs = -1;
    logic          pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [DW-1:0] pd = '0;
    for (int k = 0; k < n; k++) begin
      int ad = (a + k * s) % Size;
      addr_q.push_back(ad);
      exp_d.push_back(mem[ad]);
      exp_l.push_back(k == n - 1);
    end
    for (int it = 0; it < 300 + 20 * n; it++) begin
      @(negedge clk);
      m_tready = ($urandom_range(99) < pct);
      if (acc < 0) begin
        cmd_valid = 1'b1; cmd_addr = AW'(a); cmd_len = LW'(n); cmd_stride = AW'(s);
      end else if (hold) begin
        cmd_valid = 1'b1; cmd_addr = AW'(na); cmd_len = LW'(nn); cmd_stride = AW'(ns);
      end else begin
        cmd_valid = 1'b0;
      end
      #1;
      if (acc < 0) begin
        if (it == 0) begin
          chk("cmd_ready_idle", cmd_ready, 1);
          chk("busy_idle", busy, 0);
          chk("tvalid_idle", m_tvalid, 0);
        end
        if (cmd_ready) acc = it;
        if (acc >= 0 && n == 0) return;
        continue;
      end
      chk("cmd_ready_busy", cmd_ready, 0);
      chk("busy_active", busy, 1);
      if (bram_en) begin
        issued++;
        if (addr_q.size() == 0) chk("issue_count", issued, n);
        else chk("bram_addr", bram_addr, 32'(addr_q.pop_front()));
      end
      if (pv && !pr) begin
        chk("stall_tvalid", m_tvalid, 1);
        chk("stall_tdata", m_tdata, pd);
        chk("stall_tlast", m_tlast, pl);
      end
      if (m_tvalid && first < 0) begin
        first = it - acc;
        chk("first_latency", first, FirstLat);
      end
      if (m_tvalid && m_tready) begin
        if (exp_d.size() == 0) chk("beat_count", got + 1, n);
        else begin
          chk("tdata", m_tdata, exp_d.pop_front());
          chk("tlast", m_tlast, exp_l.pop_front());
        end
        got++;
        if (first_hs < 0) first_hs = it;
        last_hs = it;
      end
      chk("credit", (issued - got) <= Depth, 1);
      pv = m_tvalid; pr = m_tready; pd = m_tdata; pl = m_tlast;
      if (got == n) begin
        if (pct >= 100) chk("throughput", last_hs - first_hs, n - 1);
        chk("issued_total", issued, n);
        return;
      end
      if (got == max_beats) return;
    end
    chk("timeout_beats", got, n);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      chk("idle_ready", cmd_ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_tvalid", m_tvalid, 0);
      chk("idle_bram_en", bram_en, 0);
    end
  endtask

  task automatic mid_reset();
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b0; m_tready = 1'b1;
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    #1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_bram_en", bram_en, 0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", cmd_ready, 1);
    chk("rst_release_busy", busy, 0);
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_stride = '0; m_tready = 1'b0;
    for (int i = 0; i < Size; i++) mem[i] = DW'(i);
    @(negedge clk);
    #1;
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_bram_en", bram_en, 0);
    chk("reset_bram_addr", bram_addr, 0);
    chk("reset_tvalid", m_tvalid, 0);
    chk("reset_tlast", m_tlast, 0);
    chk("reset_tdata", m_tdata, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", cmd_ready, 1);

    run_burst(5, 4, 1, 100, -1, 0, 0, 0, 0);
    run_burst(500, 3, 8, 100, -1, 0, 0, 0, 0);

    for (int i = 0; i < Size; i++) mem[i] = DW'($urandom);
    run_burst(int'($urandom_range(511)), 16, int'($urandom_range(1, 511)), 30, -1, 0, 0, 0, 0);
    run_burst(7, 0, 1, 100, -1, 0, 0, 0, 0);
    idle(3);
    run_burst(42, 5, 0, 70, -1, 0, 0, 0, 0);
    for (int r = 0; r < 6; r++)
      run_burst(int'($urandom_range(511)), int'($urandom_range(1, 40)),
                int'($urandom_range(511)), int'($urandom_range(20, 100)), -1, 0, 0, 0, 0);

    run_burst(100, 10, 3, 100, 3, 0, 0, 0, 0);
    mid_reset();
    run_burst(200, 2, 5, 50, -1, 0, 0, 0, 0);

    run_burst(10, 6, 2, 60, -1, 1, 300, 5, 7);
    run_burst(300, 5, 7, 60, -1, 0, 0, 0, 0);

    run_burst(0, MaxLen, 1, 100, -1, 0, 0, 0, 0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
